// File: rtl/lobster_fetch_queue_if.sv
// lobster_fetch_queue_if
//   Bundles the SRAM read port, the redirect request and the instruction
//   output stream of the lobster128 fetch queue.
//   Parameters: ADDR_WIDTH (byte address width), QUEUE_DEPTH (sizes occupancy).
//   Signals:
//     mem_ce / mem_addr          read request towards SRAM
//     mem_rdy / mem_data         SRAM response
//     redirect_valid/redirect_pc flush and restart fetch
//     out_valid / out_ready      instruction handshake towards execution
//     out_insn / out_kind / out_pc  queue head contents
//     occupancy                  current queue entry count
//   Modports: master = fetch queue side, slave = SRAM/consumer/redirect side.
interface lobster_fetch_queue_if #(
    parameter int unsigned ADDR_WIDTH  = 36,
    parameter int unsigned QUEUE_DEPTH = 8
);
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);

    logic                  mem_ce;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rdy;
    logic [63:0]           mem_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [63:0]           out_insn;
    logic                  out_kind;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [OCC_W-1:0]      occupancy;

    modport master (
        output mem_ce, mem_addr,
        input  mem_rdy, mem_data,
        input  redirect_valid, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_insn, out_kind, out_pc, occupancy
    );

    modport slave (
        input  mem_ce, mem_addr,
        output mem_rdy, mem_data,
        output redirect_valid, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_insn, out_kind, out_pc, occupancy
    );
endinterface

// File: rtl/lobster_fetch_queue.sv
// lobster_fetch_queue
//   Decoupled instruction prefetcher for the lobster128 core: issues 64-bit
//   SRAM reads, classifies each word (micro bundle or long instruction),
//   queues the resulting entries and delivers one per cycle downstream.
//   Optional feature macro: LOBSTER_FETCH_SPLIT_EN -- when defined, micro
//   bundles are split into four 16-bit entries and an unaligned redirect
//   drops the leading slots of the first returned bundle.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   lobster_fetch_queue_if.master (SRAM port, redirect, output stream)
module lobster_fetch_queue #(
    parameter int unsigned           ADDR_WIDTH  = 36,
    parameter int unsigned           QUEUE_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 'hF800
) (
    input  logic                 clk,
    input  logic                 rst,
    lobster_fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);
`ifdef LOBSTER_FETCH_SPLIT_EN
    localparam int unsigned SLOTS = 4;
`else
    localparam int unsigned SLOTS = 1;
`endif

    // Queue storage
    logic [63:0]            r_insn [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  r_pc   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] r_kind;
    logic [PTR_W-1:0]       r_rptr;
    logic [PTR_W-1:0]       r_wptr;
    logic [OCC_W-1:0]       r_count;

    // Fetch side
    logic                   r_mem_ce;
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
`ifdef LOBSTER_FETCH_SPLIT_EN
    logic [1:0]             r_skip;
    logic                   w_is_micro;
`endif

    logic                   w_out_valid;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_ce_nxt;
    logic [OCC_W-1:0]       w_push_n;
    logic [OCC_W-1:0]       w_push_cnt;
    logic [OCC_W-1:0]       w_count_nxt;
    logic [SLOTS-1:0]       w_ent_en;
    logic [SLOTS-1:0]       w_ent_kind;
    logic [63:0]            w_ent_insn [SLOTS];
    logic [ADDR_WIDTH-1:0]  w_ent_pc   [SLOTS];
    logic [PTR_W-1:0]       w_ent_idx  [SLOTS];

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    // A response arriving together with a redirect belongs to the old stream.
    assign w_capture   = r_mem_ce & bus.mem_rdy & ~bus.redirect_valid;

    // Build the entries produced by the word on mem_data. Entry k is the
    // k-th surviving slot, written at wptr+k.
    always_comb begin
        w_ent_en = '0;
        w_ent_kind = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            w_ent_insn[k] = '0;
            w_ent_pc[k]   = r_fetch_pc;
            w_ent_idx[k]  = r_wptr + PTR_W'(k);
        end
`ifdef LOBSTER_FETCH_SPLIT_EN
        w_is_micro = (bus.mem_data[1:0] == 2'b00);
        if (w_is_micro) begin
            w_push_n = OCC_W'(3'd4 - {1'b0, r_skip});
            for (int unsigned k = 0; k < SLOTS; k++) begin
                // slot index = k + skip; only slots 0..3 exist
                if ((3'(k) + {1'b0, r_skip}) < 3'd4) begin
                    w_ent_en[k]   = 1'b1;
                    w_ent_kind[k] = 1'b0;
                    w_ent_insn[k] = {48'h0, bus.mem_data[{2'(k) + r_skip, 4'b0000} +: 16]};
                    w_ent_pc[k]   = {r_fetch_pc[ADDR_WIDTH-1:3], 2'(k) + r_skip, 1'b0};
                end
            end
        end else begin
            w_push_n      = OCC_W'(1);
            w_ent_en[0]   = 1'b1;
            w_ent_kind[0] = 1'b1;
            w_ent_insn[0] = bus.mem_data;
        end
`else
        w_push_n      = OCC_W'(1);
        w_ent_en[0]   = 1'b1;
        w_ent_kind[0] = (bus.mem_data[1:0] != 2'b00);
        w_ent_insn[0] = bus.mem_data;
`endif
    end

    always_comb begin
        w_push_cnt  = w_capture ? w_push_n : '0;
        w_count_nxt = r_count + w_push_cnt - OCC_W'(w_pop);
        // Request only when a whole word is guaranteed to fit on return.
        w_ce_nxt    = (w_count_nxt <= OCC_W'(QUEUE_DEPTH - SLOTS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_mem_ce   <= 1'b0;
            r_fetch_pc <= RESET_PC;
`ifdef LOBSTER_FETCH_SPLIT_EN
            r_skip     <= '0;
`endif
        end else if (bus.redirect_valid) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_mem_ce   <= 1'b1;
            r_fetch_pc <= {bus.redirect_pc[ADDR_WIDTH-1:3], 3'b000};
`ifdef LOBSTER_FETCH_SPLIT_EN
            r_skip     <= bus.redirect_pc[2:1];
`endif
        end else begin
            if (w_capture) begin
                r_wptr     <= r_wptr + PTR_W'(w_push_n);
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(8);
`ifdef LOBSTER_FETCH_SPLIT_EN
                r_skip     <= '0;
`endif
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count  <= w_count_nxt;
            r_mem_ce <= w_ce_nxt;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (!rst && w_capture) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (w_ent_en[k]) begin
                    r_insn[w_ent_idx[k]] <= w_ent_insn[k];
                    r_pc[w_ent_idx[k]]   <= w_ent_pc[k];
                    r_kind[w_ent_idx[k]] <= w_ent_kind[k];
                end
            end
        end
    end

    assign bus.mem_ce    = r_mem_ce;
    assign bus.mem_addr  = r_fetch_pc;
    assign bus.out_valid = w_out_valid;
    assign bus.out_insn  = r_insn[r_rptr];
    assign bus.out_kind  = r_kind[r_rptr];
    assign bus.out_pc    = r_pc[r_rptr];
    assign bus.occupancy = r_count;
endmodule

// File: tb/tb_lobster_fetch_queue.sv
// tb_lobster_fetch_queue
//   Directed bench for lobster_fetch_queue: a per-cycle vector table of
//   {inputs, expected registered outputs}, then hand-written sequences for
//   backpressure fill/drain, SRAM stall, reset mid-request and PC wrap on a
//   12-bit address instance. Expectations follow LOBSTER_FETCH_SPLIT_EN.
module tb_lobster_fetch_queue;
    localparam logic [63:0] W1 = 64'h1111_2222_3333_0001;
    localparam logic [63:0] W2 = 64'hAAAA_BBBB_CCCC_DDD0;
    localparam logic [63:0] W3 = 64'h4444_3330_2220_1110;
    localparam logic [63:0] W4 = 64'h0000_0000_0000_0ABF;

    logic clk;
    logic rst;

    lobster_fetch_queue_if #(.ADDR_WIDTH(36), .QUEUE_DEPTH(8)) bus ();
    lobster_fetch_queue_if #(.ADDR_WIDTH(12), .QUEUE_DEPTH(8)) wbus ();

    lobster_fetch_queue #(.ADDR_WIDTH(36), .QUEUE_DEPTH(8), .RESET_PC(36'hF800)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    lobster_fetch_queue #(.ADDR_WIDTH(12), .QUEUE_DEPTH(8), .RESET_PC(12'hFF8)) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [63:0] data;
        logic        ordy;
        logic        redir;
        logic [35:0] rpc;
        logic        e_ce;
        logic [35:0] e_addr;
        logic        e_valid;
        logic [63:0] e_insn;
        logic        e_kind;
        logic [35:0] e_pc;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic vec_t mk(input logic rdy, input logic [63:0] data, input logic ordy,
                                input logic redir, input logic [35:0] rpc,
                                input logic e_ce, input logic [35:0] e_addr, input logic e_valid,
                                input logic [63:0] e_insn, input logic e_kind,
                                input logic [35:0] e_pc, input logic [3:0] e_occ);
        vec_t v;
        v.rdy = rdy; v.data = data; v.ordy = ordy; v.redir = redir; v.rpc = rpc;
        v.e_ce = e_ce; v.e_addr = e_addr; v.e_valid = e_valid; v.e_insn = e_insn;
        v.e_kind = e_kind; v.e_pc = e_pc; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [63:0] data, input logic ordy,
                         input logic redir, input logic [35:0] rpc);
        bus.mem_rdy = rdy;
        bus.mem_data = data;
        bus.out_ready = ordy;
        bus.redirect_valid = redir;
        bus.redirect_pc = rpc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        wbus.mem_rdy = 1'b0; wbus.mem_data = '0; wbus.out_ready = 1'b0;
        wbus.redirect_valid = 1'b0; wbus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_insn [4];
        logic [35:0] exp_pc [4];
        logic        exp_ce_drain [4];

        // ---------------- vector table ----------------
        vecs.push_back(mk(0, '0,    0, 0, '0,      0, 36'hF800, 0, '0, 0, '0, 4'd0));
`ifdef LOBSTER_FETCH_SPLIT_EN
        vecs.push_back(mk(1, W3,    1, 0, '0,      1, 36'hF800, 0, '0,       0, '0,       4'd0));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'hF808, 1, 64'h1110, 0, 36'hF800, 4'd4));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'hF808, 1, 64'h2220, 0, 36'hF802, 4'd3));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'hF808, 1, 64'h3330, 0, 36'hF804, 4'd2));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'hF808, 1, 64'h4444, 0, 36'hF806, 4'd1));
        vecs.push_back(mk(1, 64'h5, 0, 1, 36'h1004, 1, 36'hF808, 0, '0,      0, '0,       4'd0));
        vecs.push_back(mk(1, W3,    1, 0, '0,      1, 36'h1000, 0, '0,       0, '0,       4'd0));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'h1008, 1, 64'h3330, 0, 36'h1004, 4'd2));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'h1008, 1, 64'h4444, 0, 36'h1006, 4'd1));
        vecs.push_back(mk(1, W3,    0, 0, '0,      1, 36'h1008, 0, '0,       0, '0,       4'd0));
        vecs.push_back(mk(0, '0,    0, 0, '0,      1, 36'h1010, 1, 64'h1110, 0, 36'h1008, 4'd4));
        vecs.push_back(mk(0, '0,    1, 1, 36'h2006, 1, 36'h1010, 1, 64'h1110, 0, 36'h1008, 4'd4));
        vecs.push_back(mk(1, W4,    0, 0, '0,      1, 36'h2000, 0, '0,       0, '0,       4'd0));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'h2008, 1, W4,       1, 36'h2000, 4'd1));
        vecs.push_back(mk(0, '0,    0, 0, '0,      1, 36'h2008, 0, '0,       0, '0,       4'd0));
`else
        vecs.push_back(mk(1, W1,    0, 0, '0,      1, 36'hF800, 0, '0, 0, '0,       4'd0));
        vecs.push_back(mk(1, W2,    0, 0, '0,      1, 36'hF808, 1, W1, 1, 36'hF800, 4'd1));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'hF810, 1, W1, 1, 36'hF800, 4'd2));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'hF810, 1, W2, 0, 36'hF808, 4'd1));
        vecs.push_back(mk(0, '0,    0, 0, '0,      1, 36'hF810, 0, '0, 0, '0,       4'd0));
        vecs.push_back(mk(1, 64'h5, 0, 1, 36'h1004, 1, 36'hF810, 0, '0, 0, '0,      4'd0));
        vecs.push_back(mk(1, W3,    1, 0, '0,      1, 36'h1000, 0, '0, 0, '0,       4'd0));
        vecs.push_back(mk(0, '0,    1, 0, '0,      1, 36'h1008, 1, W3, 0, 36'h1000, 4'd1));
        vecs.push_back(mk(0, '0,    0, 0, '0,      1, 36'h1008, 0, '0, 0, '0,       4'd0));
        vecs.push_back(mk(1, W1,    0, 0, '0,      1, 36'h1008, 0, '0, 0, '0,       4'd0));
        vecs.push_back(mk(0, '0,    1, 1, 36'h2000, 1, 36'h1010, 1, W1, 1, 36'h1008, 4'd1));
        vecs.push_back(mk(0, '0,    0, 0, '0,      1, 36'h2000, 0, '0, 0, '0,       4'd0));
`endif

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].data, vecs[i].ordy, vecs[i].redir, vecs[i].rpc);
            @(negedge clk);
            check($sformatf("row%0d mem_ce", i), 64'(bus.mem_ce), 64'(vecs[i].e_ce));
            check($sformatf("row%0d mem_addr", i), 64'(bus.mem_addr), 64'(vecs[i].e_addr));
            check($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_valid));
            check($sformatf("row%0d occupancy", i), 64'(bus.occupancy), 64'(vecs[i].e_occ));
            if (vecs[i].e_valid) begin
                check($sformatf("row%0d out_insn", i), bus.out_insn, vecs[i].e_insn);
                check($sformatf("row%0d out_kind", i), 64'(bus.out_kind), 64'(vecs[i].e_kind));
                check($sformatf("row%0d out_pc", i), 64'(bus.out_pc), 64'(vecs[i].e_pc));
            end
            next_cycle();
        end

        // ---------------- backpressure fill then drain ----------------
        do_reset();
        drive(1'b1, W3, 1'b0, 1'b0, '0);
`ifdef LOBSTER_FETCH_SPLIT_EN
        // two bundles fill eight entries; request drops until four pops
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("fill%0d mem_ce", c), 64'(bus.mem_ce), (c == 1 || c == 2) ? 64'd1 : 64'd0);
            check($sformatf("fill%0d occupancy", c), 64'(bus.occupancy),
                  (c < 2) ? 64'd0 : (c == 2) ? 64'd4 : 64'd8);
            next_cycle();
        end
        exp_insn = '{64'h1110, 64'h2220, 64'h3330, 64'h4444};
        exp_pc   = '{36'hF800, 36'hF802, 36'hF804, 36'hF806};
        exp_ce_drain = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            check($sformatf("fill%0d mem_ce", c), 64'(bus.mem_ce), (c >= 1 && c <= 8) ? 64'd1 : 64'd0);
            check($sformatf("fill%0d occupancy", c), 64'(bus.occupancy),
                  (c == 0) ? 64'd0 : (c > 9) ? 64'd8 : 64'(c - 1));
            next_cycle();
        end
        exp_insn = '{W3, W3, W3, W3};
        exp_pc   = '{36'hF800, 36'hF808, 36'hF810, 36'hF818};
        exp_ce_drain = '{1'b0, 1'b1, 1'b1, 1'b1};
`endif
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            check($sformatf("drain%0d mem_ce", d), 64'(bus.mem_ce), 64'(exp_ce_drain[d]));
            check($sformatf("drain%0d occupancy", d), 64'(bus.occupancy), 64'(8 - d));
            check($sformatf("drain%0d out_insn", d), bus.out_insn, exp_insn[d]);
            check($sformatf("drain%0d out_pc", d), 64'(bus.out_pc), 64'(exp_pc[d]));
            next_cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("drain_end mem_ce", 64'(bus.mem_ce), 64'd1);
        check("drain_end occupancy", 64'(bus.occupancy), 64'd4);
        next_cycle();

        // ---------------- SRAM stall holds the request ----------------
        do_reset();
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d mem_ce", c), 64'(bus.mem_ce), 64'd1);
            check($sformatf("stall%0d mem_addr", c), 64'(bus.mem_addr), 64'hF800);
            check($sformatf("stall%0d occupancy", c), 64'(bus.occupancy), 64'd0);
            next_cycle();
        end

        // reset while the request is pending, with a response arriving
        rst = 1'b1;
        drive(1'b1, W1, 1'b0, 1'b0, '0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("rstmid mem_ce", 64'(bus.mem_ce), 64'd0);
        check("rstmid mem_addr", 64'(bus.mem_addr), 64'hF800);
        check("rstmid out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmid occupancy", 64'(bus.occupancy), 64'd0);
        next_cycle();

        // ---------------- address wrap on 12-bit instance ----------------
        do_reset();
        @(negedge clk);
        check("wrap reset mem_addr", 64'(wbus.mem_addr), 64'hFF8);
        check("wrap reset mem_ce", 64'(wbus.mem_ce), 64'd0);
        next_cycle();
        wbus.mem_rdy = 1'b1;
        wbus.mem_data = 64'h0000_0000_0000_0003;
        @(negedge clk);
        check("wrap req mem_ce", 64'(wbus.mem_ce), 64'd1);
        check("wrap req mem_addr", 64'(wbus.mem_addr), 64'hFF8);
        next_cycle();
        wbus.mem_rdy = 1'b0;
        @(negedge clk);
        check("wrap next mem_addr", 64'(wbus.mem_addr), 64'h000);
        check("wrap out_valid", 64'(wbus.out_valid), 64'd1);
        check("wrap out_pc", 64'(wbus.out_pc), 64'hFF8);
        check("wrap out_kind", 64'(wbus.out_kind), 64'd1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lobster_fetch_queue.md
# lobster_fetch_queue

Parametrised instruction-fetch front end for the lobster128 core. It generalises the single-word fetch path into a decoupled prefetcher with a configurable-depth instruction queue, a clean SRAM read handshake, redirect/flush support and micro-bundle splitting. It sits between the SRAM port and the execution engine, and delivers one decoded-kind instruction per cycle over a valid/ready interface.

## Interface
- ADDR_WIDTH, 36, byte-address width of fetch PC and SRAM address
- QUEUE_DEPTH, 8, instruction queue entries; power of two, ≥4
- RESET_PC, 'hF800, fetch PC after reset (8-byte aligned)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_ce  out  1  read request to SRAM
- mem_addr  out  ADDR_WIDTH  word address of request, low 3 bits always 0
- mem_rdy  in  1  SRAM data valid this cycle
- mem_data  in  64  fetched instruction word
- redirect_valid  in  1  flush queue and restart fetch
- redirect_pc  in  ADDR_WIDTH  new fetch byte address
- out_valid  out  1  queue head valid
- out_ready  in  1  consumer accepts head
- out_insn  out  64  instruction; micro slots zero-extended in [15:0]
- out_kind  out  1  0 = micro instruction, 1 = long instruction
- out_pc  out  ADDR_WIDTH  byte address of the instruction
- occupancy  out  $clog2(QUEUE_DEPTH+1)  current entry count

## Operation
- Word classification by mem_data[1:0]: 00 = micro bundle (four 16-bit slots, slot i = bits[16i+15:16i], pc = word_pc + 2i); any other value = long instruction (whole word, pc = word_pc).
- Capture occurs in a cycle with mem_ce=1 and mem_rdy=1. Entries are pushed in slot order; fetch PC then advances by 8, wrapping modulo 2^ADDR_WIDTH.
- SLOTS = 4 when splitting is enabled, else 1.
- mem_ce is registered. It is asserted next cycle iff free entries after this cycle's push/pop ≥ SLOTS. A captured word therefore always fits.
- While mem_ce=1 and mem_rdy=0, mem_ce and mem_addr hold stable; the request is never withdrawn except by redirect or reset.
- Pop: out_valid & out_ready removes the head. Push and pop in the same cycle are both honoured.
- Read and write pointers wrap at QUEUE_DEPTH.
- Redirect has priority over everything:
  - the queue is emptied;
  - any data captured that cycle is discarded;
  - a pop that same cycle counts as consumed;
  - next cycle mem_ce=1 with mem_addr = redirect_pc & ~7.
- Redirect to an unaligned PC (split enabled): in the first returned word, slots below redirect_pc[2:1] are dropped. A long word returned at an unaligned redirect is pushed whole.
- A redirect while a request is pending is legal. The old response is discarded, and the new request starts next cycle.

## Timing
- Reset values: mem_ce=0, mem_addr=RESET_PC, out_valid=0, occupancy=0. Pointers are 0, and skip-slot state is cleared.
- First cycle after rst deasserts: mem_ce=1, mem_addr=RESET_PC.
- Latency: a capture at edge N makes out_valid=1 with the first entry at N+1.
- Throughput: with mem_rdy tied high and the consumer always ready, one word is captured per cycle in non-split mode. In split mode, the fetch rate is limited by the 1-per-cycle drain.
- out_* are driven directly from the queue head register (no combinational path from mem_data).
- Reset asserted mid-request: all state is returned to reset values at that edge, and the pending response is ignored.

## Configuration
- LOBSTER_FETCH_SPLIT_EN defined: micro bundles are split into four entries, SLOTS=4, and unaligned redirect skipping is active.
- LOBSTER_FETCH_SPLIT_EN undefined:
  - every word is one entry with out_kind per mem_data[1:0];
  - out_insn carries the full word and out_pc = word_pc;
  - SLOTS=1 and redirect low bits are ignored.

## Test plan
- Reset, then mem_rdy=1, word 0x...0001 at 0xF800 → mem_addr=0xF800 the cycle after reset, then 0xF808; out_kind=1, out_pc=0xF800.
- Split on: micro bundle 0x4444_3330_2220_1110 at 0xF800 → four pops with out_insn 0x1110, 0x2220, 0x3330, 0x4444 and out_pc 0xF800, 0xF802, 0xF804, 0xF806.
- QUEUE_DEPTH=8, split on, out_ready=0 → occupancy reaches 8 after two words, mem_ce=0. One pop leaves mem_ce at 0; after four pops mem_ce returns to 1.
- mem_rdy held 0 for 5 cycles → mem_ce and mem_addr stable throughout, and occupancy unchanged.
- Pending request plus redirect_pc=0x1004 → old response dropped, then mem_addr=0x1000. First bundle yields only slots 2 and 3 with out_pc 0x1004 and 0x1006.
- ADDR_WIDTH=12, fetch from 0xFF8 → next mem_addr=0x000.
